instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the instruction FIFO entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-006 The block SHALL have port redirect_pc  input  32  redirect target address.
REQ-007 The block SHALL have port imem_req  output  1  instruction-memory fetch request.
REQ-008 The block SHALL have port imem_addr  output  32  fetch address.
REQ-009 The block SHALL have port imem_gnt  input  1  memory accepts the request this cycle.
REQ-010 The block SHALL have port imem_rvalid  input  1  read data valid; responses return in request order.
REQ-011 The block SHALL have port imem_rdata  input  32  instruction word.
REQ-012 The block SHALL have port instr_valid  output  1  FIFO head holds a valid instruction.
REQ-013 The block SHALL have port instr_out  output  32  head instruction word.
REQ-014 The block SHALL have port instr_pc  output  32  address of the head instruction.
REQ-015 The block SHALL have port instr_ready  input  1  downstream decode consumes the head.

Function
REQ-016 The block SHALL keep fetch_pc (next request address), resp_pc (address of next live response), P (granted, unreturned requests, 0..DEPTH), D (responses to discard, D<=P) and count (FIFO occupancy, 0..DEPTH).
REQ-017 The block SHALL drive imem_req=1 iff !redirect_valid and P+count<DEPTH; imem_addr SHALL equal fetch_pc at all times.
REQ-018 On imem_req&&imem_gnt the block SHALL increment P and set fetch_pc<=fetch_pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 On imem_rvalid with P>0 the block SHALL decrement P, and decrement D if D>0 (word discarded), otherwise push {imem_rdata, resp_pc} into the FIFO and set resp_pc<=resp_pc+4.
REQ-020 imem_rvalid while P==0 SHALL be ignored with no state change.
REQ-021 Grant and response in the same cycle SHALL be applied together, leaving P unchanged.
REQ-022 instr_valid SHALL equal (count!=0); instr_out/instr_pc SHALL present the head entry; pop occurs on instr_valid&&instr_ready.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; push into a full FIFO cannot occur by REQ-017.
REQ-024 Latency: grant in cycle N, earliest rvalid N+1, earliest instr_valid N+2 (no FIFO bypass).
REQ-025 On redirect_valid the block SHALL flush the FIFO (count<=0), set fetch_pc and resp_pc to {redirect_pc[31:2],2'b00}, set D<=P-imem_rvalid, and discard any same-cycle response.
REQ-026 Redirect SHALL take priority over pop; instr_ready is ignored in a redirect cycle.
REQ-027 The cycle after redirect, imem_req SHALL rise only once P+count<DEPTH holds (stale responses drain first).
REQ-028 While imem_req=1 and imem_gnt=0, imem_addr SHALL stay stable; only a redirect may withdraw the request.

Reset
REQ-029 While reset is high: imem_req=0, instr_valid=0, instr_out=0, instr_pc=0, P=D=count=0, fetch_pc=resp_pc=RESET_PC.
REQ-030 Reset asserted mid-operation SHALL abandon all outstanding requests and FIFO contents immediately, without waiting for clk.
REQ-031 First cycle after reset release: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-032 Streaming: gnt=1 always, rvalid one cycle after each grant, ready=1 -> instr_pc sequence 0,4,8,12..., one instruction per cycle after 2-cycle startup.
REQ-033 Backpressure: ready=0, memory always grants -> exactly DEPTH (4) entries at PCs 0..12, imem_req=0 while full; ready=1 -> drains in order, fetch resumes at 16.
REQ-034 Redirect with 2 requests outstanding: redirect_pc=32'h100 -> instr_valid=0 next cycle, next 2 rvalids discarded, first delivered instr_pc=32'h100.
REQ-035 Misaligned redirect_pc=32'h203 -> imem_addr=32'h200.
REQ-036 Wrap: redirect to 32'hFFFF_FFF8 -> delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Reset asserted with FIFO holding 3 entries and P=1 -> outputs per REQ-029 immediately; fetch restarts at RESET_PC and the late rvalid with P=0 is ignored.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - in-order instruction fetch with redirect flush and response discard
// Tracks outstanding memory requests so stale responses after a redirect are dropped.
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] p_cnt;
   logic [CW-1:0] d_cnt;
   logic [CW-1:0] count;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];

   logic [CW:0]   inflight;
   logic          grant;
   logic          rsp;
   logic          discard;
   logic          push;
   logic          pop;
   logic [31:0]   redirect_aligned;

   // Outstanding requests reserve FIFO slots, so a push can never find the FIFO full.
   assign inflight         = {1'b0, p_cnt} + {1'b0, count};
   assign imem_req         = !reset && !redirect_valid && (inflight < (CW+1)'(DEPTH));
   assign imem_addr        = fetch_pc;
   assign grant            = imem_req && imem_gnt;
   assign rsp              = imem_rvalid && (p_cnt != '0);
   assign discard          = rsp && (d_cnt != '0);
   assign push             = rsp && !discard && !redirect_valid;
   assign pop              = instr_valid && instr_ready && !redirect_valid;
   assign redirect_aligned = {redirect_pc[31:2], 2'b00};

   assign instr_valid = (count != '0);
   assign instr_out   = instr_valid ? data_mem[rd_ptr] : 32'h0;
   assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 32'h0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         p_cnt    <= '0;
         d_cnt    <= '0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else if (redirect_valid) begin
         // Every request still in flight belongs to the old path and must be dropped.
         fetch_pc <= redirect_aligned;
         resp_pc  <= redirect_aligned;
         p_cnt    <= p_cnt - CW'(rsp);
         d_cnt    <= p_cnt - CW'(rsp);
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         p_cnt <= p_cnt + CW'(grant) - CW'(rsp);
         if (discard) begin
            d_cnt <= d_cnt - 1'b1;
         end
         if (push) begin
            resp_pc <= resp_pc + 32'd4;
            wr_ptr  <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= imem_rdata;
         pc_mem[wr_ptr]   <= resp_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed and randomized bench for instr_fetch_queue
module tb_instr_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;

   int compared = 0;
   int mismatched = 0;

   // Reference state: instruction queue, memory request queue, counters.
   logic [31:0] qd[$];
   logic [31:0] qp[$];
   logic [31:0] mq[$];
   logic [31:0] dlog[$];
   logic [31:0] m_fetch;
   logic [31:0] m_resp;
   int          m_p;
   int          m_d;

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      qd.delete(); qp.delete(); mq.delete();
      m_fetch = RESET_PC; m_resp = RESET_PC; m_p = 0; m_d = 0;
   endtask

   // Asserted between clock edges; outputs must clear before any edge.
   task automatic do_reset();
      redirect_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_out", instr_out, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_addr", imem_addr, RESET_PC);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_req", {31'b0, imem_req}, 32'h1);
      chk("post_rst_addr", imem_addr, RESET_PC);
   endtask

   task automatic cycle(input logic redir, input logic [31:0] rpc, input logic gnt,
                        input logic rv, input logic rdy);
      logic        req_m;
      logic        grant;
      logic        rsp;
      logic [31:0] rd;
      rd = (mq.size() > 0) ? (mq[0] ^ 32'h5A5A_1234) : 32'hDEAD_BEEF;
      redirect_valid = redir; redirect_pc = rpc; imem_gnt = gnt;
      imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy;
      #1;
      req_m = !redir && (m_p + qp.size() < DEPTH);
      chk("imem_req", {31'b0, imem_req}, {31'b0, req_m});
      chk("imem_addr", imem_addr, m_fetch);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, qp.size() > 0});
      if (qp.size() > 0) begin
         chk("instr_out", instr_out, qd[0]);
         chk("instr_pc", instr_pc, qp[0]);
      end
      if (instr_valid && rdy && !redir) dlog.push_back(instr_pc);
      @(posedge clk);
      grant = req_m && gnt;
      rsp   = rv && (m_p > 0);
      if (rv && mq.size() > 0) void'(mq.pop_front());
      if (grant) mq.push_back(m_fetch);
      if (redir) begin
         qd.delete(); qp.delete();
         if (rsp) m_p--;
         m_d = m_p;
         m_fetch = {rpc[31:2], 2'b00};
         m_resp  = {rpc[31:2], 2'b00};
      end else begin
         if (rdy && qp.size() > 0) begin
            void'(qd.pop_front()); void'(qp.pop_front());
         end
         if (grant) begin
            m_p++; m_fetch = m_fetch + 32'd4;
         end
         if (rsp) begin
            m_p--;
            if (m_d > 0) m_d--;
            else begin
               qd.push_back(rd); qp.push_back(m_resp); m_resp = m_resp + 32'd4;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic stream(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b1, mq.size() > 0, rdy);
   endtask

   task automatic chk_log(input string tag, input int idx, input logic [31:0] exp);
      if (idx < dlog.size()) chk(tag, dlog[idx], exp);
      else chk({tag, "_missing"}, 32'(dlog.size()), 32'(idx + 1));
   endtask

   initial begin
      model_reset();
      @(negedge clk);

      // Streaming from reset: ten deliveries in twelve cycles.
      do_reset();
      dlog.delete();
      stream(12, 1'b1);
      chk("stream_count", 32'(dlog.size()), 32'd10);
      for (int i = 0; i < 10; i++) chk_log("stream_pc", i, 32'(4 * i));

      // Backpressure fills exactly DEPTH entries.
      do_reset();
      stream(10, 1'b0);
      chk("bp_req_full", {31'b0, imem_req}, 32'h0);
      chk("bp_addr", imem_addr, 32'd16);
      chk("bp_head", instr_pc, 32'd0);
      dlog.delete();
      stream(10, 1'b1);
      for (int i = 0; i < 6; i++) chk_log("bp_drain_pc", i, 32'(4 * i));

      // Redirect with two requests outstanding.
      do_reset();
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      chk("redir_outstanding", 32'(mq.size()), 32'd2);
      cycle(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
      chk("redir_flush", {31'b0, instr_valid}, 32'h0);
      chk("redir_addr", imem_addr, 32'h100);
      dlog.delete();
      stream(10, 1'b1);
      chk_log("redir_first", 0, 32'h100);
      chk_log("redir_second", 1, 32'h104);

      // Misaligned target is word-aligned.
      cycle(1'b1, 32'h203, 1'b0, 1'b0, 1'b1);
      chk("misalign_addr", imem_addr, 32'h200);
      dlog.delete();
      stream(8, 1'b1);
      chk_log("misalign_first", 0, 32'h200);

      // Address wrap past the top of memory.
      cycle(1'b1, 32'hFFFF_FFF8, 1'b0, mq.size() > 0, 1'b1);
      dlog.delete();
      stream(10, 1'b1);
      chk_log("wrap_0", 0, 32'hFFFF_FFF8);
      chk_log("wrap_1", 1, 32'hFFFF_FFFC);
      chk_log("wrap_2", 2, 32'h0000_0000);

      // Reset with three entries held and one request outstanding.
      do_reset();
      stream(4, 1'b0);
      chk("pre_rst_outstanding", 32'(mq.size()), 32'd1);
      chk("pre_rst_valid", {31'b0, instr_valid}, 32'h1);
      do_reset();
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      chk("late_rv_valid", {31'b0, instr_valid}, 32'h0);
      chk("late_rv_req", {31'b0, imem_req}, 32'h1);
      chk("late_rv_addr", imem_addr, RESET_PC);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 800; i++) begin
         logic redir;
         logic rv;
         redir = ($urandom % 20) == 0;
         rv = (mq.size() > 0) ? (($urandom % 3) != 0) : (($urandom % 8) == 0);
         cycle(redir, $urandom, ($urandom % 4) != 0, rv, ($urandom % 3) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
